// File: rtl/delay_pkg.sv
// Shared constants and the default stage-entry layout for the coordinate delay line.
package delay_pkg;

    localparam int DL_W           = 11;
    localparam int DL_MAX_DEPTH   = 8;
    localparam int DL_DEFAULT_DLY = 3;

    typedef struct packed {
        logic [DL_W-1:0] x;
        logic [DL_W-1:0] y;
        logic            v;
        logic            d;
    } dl_entry_t;

endpackage

// File: rtl/dl_stage.sv
// One register stage of the delay line: loads on en, drops v/d on flush, holds otherwise.
module dl_stage
    import delay_pkg::*;
#(
    parameter type T = dl_entry_t
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic flush,
    input  T     din,
    output T     dout
);

    T entry_d;
    T entry_q;

    // Flush only kills the flags; coordinates are left as they were.
    always_comb begin
        entry_d = entry_q;
        if (flush) begin
            entry_d.v = 1'b0;
            entry_d.d = 1'b0;
        end else if (en) begin
            entry_d = din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) entry_q <= '0;
        else       entry_q <= entry_d;
    end

    assign dout = entry_q;

endmodule

// File: rtl/coord_delay_line.sv
// Stallable, run-time-selectable delay line for {x, y, valid, done} coordinate streams.
module coord_delay_line
    import delay_pkg::*;
#(
    parameter int W           = DL_W,
    parameter int MAX_DEPTH   = DL_MAX_DEPTH,
    parameter int DEFAULT_DLY = DL_DEFAULT_DLY,
    parameter int DW          = $clog2(MAX_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          flush,
    input  logic [W-1:0]  x_pre,
    input  logic [W-1:0]  y_pre,
    input  logic          valid_pre,
    input  logic          done_pre,
    input  logic          cfg_load,
    input  logic [DW-1:0] cfg_dly,
    output logic [W-1:0]  x,
    output logic [W-1:0]  y,
    output logic          valid,
    output logic          done,
    output logic          busy,
    output logic [DW-1:0] dly_cur,
    output logic          cfg_err
);

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         v;
        logic         d;
    } entry_t;

    entry_t stg_in [MAX_DEPTH];
    entry_t stg_q  [MAX_DEPTH];

    generate
        for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign stg_in[k] = {x_pre, y_pre, valid_pre, done_pre};
            end else begin : g_link
                assign stg_in[k] = stg_q[k-1];
            end
            dl_stage #(.T(entry_t)) u_stage (
                .clk   (clk),
                .reset (reset),
                .en    (en),
                .flush (flush),
                .din   (stg_in[k]),
                .dout  (stg_q[k])
            );
        end
    endgenerate

    logic [DW-1:0] dly_d, dly_q;
    logic          err_d, err_q;
    logic [DW-1:0] dly_clamped;
    logic          busy_c;
    logic          cfg_ok;
    entry_t        tap;

    // Output is a plain mux off the stage registers, so a new delay shows up immediately.
    always_comb begin
        tap = '0;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            if (dly_q == DW'(k + 1)) tap = stg_q[k];
        end
    end

    // Stages past the tap still count: the delay may not shrink under live entries.
    always_comb begin
        busy_c = 1'b0;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            busy_c = busy_c | stg_q[k].v | stg_q[k].d;
        end
    end

    always_comb begin
        if (cfg_dly == '0)                  dly_clamped = DW'(1);
        else if (cfg_dly > DW'(MAX_DEPTH))  dly_clamped = DW'(MAX_DEPTH);
        else                                dly_clamped = cfg_dly;
    end

    always_comb begin
        cfg_ok = cfg_load && (!busy_c || flush);
        dly_d  = cfg_ok ? dly_clamped : dly_q;
        err_d  = cfg_load && !cfg_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dly_q <= DW'(DEFAULT_DLY);
            err_q <= 1'b0;
        end else begin
            dly_q <= dly_d;
            err_q <= err_d;
        end
    end

    assign x       = tap.x;
    assign y       = tap.y;
    assign valid   = tap.v;
    assign done    = tap.d;
    assign busy    = busy_c;
    assign dly_cur = dly_q;
    assign cfg_err = err_q;

endmodule

// File: tb/tb_coord_delay_line.sv
// Directed-vector bench for coord_delay_line: table segments plus hand-written corner sequences.
module tb_coord_delay_line;

    logic        clk = 1'b0;
    logic        reset, en, flush, valid_pre, done_pre, cfg_load;
    logic [10:0] x_pre, y_pre;
    logic [3:0]  cfg_dly;
    logic [10:0] x, y;
    logic        valid, done, busy, cfg_err;
    logic [3:0]  dly_cur;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    coord_delay_line dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .x_pre     (x_pre),
        .y_pre     (y_pre),
        .valid_pre (valid_pre),
        .done_pre  (done_pre),
        .cfg_load  (cfg_load),
        .cfg_dly   (cfg_dly),
        .x         (x),
        .y         (y),
        .valid     (valid),
        .done      (done),
        .busy      (busy),
        .dly_cur   (dly_cur),
        .cfg_err   (cfg_err)
    );

    typedef struct {
        logic        en, flush;
        logic [10:0] xp, yp;
        logic        vp, dp;
        logic [10:0] ex, ey;
        logic        ev, ed, eb, cxy;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(logic e, logic f, int xp, int yp, logic vp, logic dp,
                                int ex, int ey, logic ev, logic ed, logic eb, logic cxy);
        vec_t r;
        r.en = e;  r.flush = f;
        r.xp = 11'(xp); r.yp = 11'(yp); r.vp = vp; r.dp = dp;
        r.ex = 11'(ex); r.ey = 11'(ey); r.ev = ev; r.ed = ed; r.eb = eb; r.cxy = cxy;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        en = 1'b1; flush = 1'b0; cfg_load = 1'b0; cfg_dly = '0;
        x_pre = '0; y_pre = '0; valid_pre = 1'b0; done_pre = 1'b0;
    endtask

    task automatic run_vec(input int i);
        en = tbl[i].en; flush = tbl[i].flush;
        x_pre = tbl[i].xp; y_pre = tbl[i].yp;
        valid_pre = tbl[i].vp; done_pre = tbl[i].dp;
        tick();
        chk($sformatf("v%0d.valid", i), int'(valid), int'(tbl[i].ev));
        chk($sformatf("v%0d.done", i),  int'(done),  int'(tbl[i].ed));
        chk($sformatf("v%0d.busy", i),  int'(busy),  int'(tbl[i].eb));
        if (tbl[i].cxy) begin
            chk($sformatf("v%0d.x", i), int'(x), int'(tbl[i].ex));
            chk($sformatf("v%0d.y", i), int'(y), int'(tbl[i].ey));
        end
    endtask

    task automatic drain();
        idle_in();
        repeat (9) tick();
        chk("drain.busy", int'(busy), 0);
    endtask

    initial begin
        // delay 3: A then B, each emerging three edges after sampling
        tbl[0]  = mk(1,0, 5, 9,1,0,  0, 0,0,0,1,1);
        tbl[1]  = mk(1,0, 6,10,1,1,  0, 0,0,0,1,1);
        tbl[2]  = mk(1,0, 0, 0,0,0,  5, 9,1,0,1,1);
        tbl[3]  = mk(1,0, 0, 0,0,0,  6,10,1,1,1,1);
        tbl[4]  = mk(1,0, 0, 0,0,0,  0, 0,0,0,1,1);
        // stalls: junk presented while stalled must never be captured
        tbl[5]  = mk(1,0, 5, 9,1,0,  0, 0,0,0,1,1);
        tbl[6]  = mk(0,0,99,99,1,1,  0, 0,0,0,1,1);
        tbl[7]  = mk(0,0,99,99,1,1,  0, 0,0,0,1,1);
        tbl[8]  = mk(1,0, 6,10,1,1,  0, 0,0,0,1,1);
        tbl[9]  = mk(1,0, 0, 0,0,0,  5, 9,1,0,1,1);
        tbl[10] = mk(0,0,99,99,1,1,  5, 9,1,0,1,1);
        tbl[11] = mk(1,0, 0, 0,0,0,  6,10,1,1,1,1);
        tbl[12] = mk(1,0, 0, 0,0,0,  0, 0,0,0,1,1);
        // flush with two in flight plus a simultaneous valid input, then a done-only entry
        tbl[13] = mk(1,0, 5, 9,1,0,  0, 0,0,0,1,1);
        tbl[14] = mk(1,0, 6,10,1,1,  0, 0,0,0,1,1);
        tbl[15] = mk(1,1,77,77,1,1,  0, 0,0,0,0,0);
        tbl[16] = mk(1,0, 0, 0,0,0,  0, 0,0,0,0,0);
        tbl[17] = mk(1,0, 0, 0,0,0,  0, 0,0,0,0,0);
        tbl[18] = mk(1,0, 3, 4,0,1,  0, 0,0,0,1,0);
        tbl[19] = mk(1,0, 0, 0,0,0,  0, 0,0,0,1,0);
        tbl[20] = mk(1,0, 0, 0,0,0,  3, 4,0,1,1,1);

        idle_in();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst.x", int'(x), 0);
        chk("rst.y", int'(y), 0);
        chk("rst.valid", int'(valid), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.dly_cur", int'(dly_cur), 3);
        chk("rst.cfg_err", int'(cfg_err), 0);

        for (int i = 0; i <= 4; i++) run_vec(i);
        drain();
        for (int i = 5; i <= 12; i++) run_vec(i);
        drain();
        for (int i = 13; i <= 20; i++) run_vec(i);
        drain();

        // idle reconfiguration to 6, then one entry must take exactly six edges
        cfg_load = 1'b1; cfg_dly = 4'd6;
        tick();
        cfg_load = 1'b0;
        chk("cfg6.dly_cur", int'(dly_cur), 6);
        chk("cfg6.cfg_err", int'(cfg_err), 0);
        x_pre = 11'd7; y_pre = 11'd8; valid_pre = 1'b1;
        tick();
        idle_in();
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("d6.valid.e%0d", k), int'(valid), (k == 6) ? 1 : 0);
            if (k == 6) chk("d6.x", int'(x), 7);
            tick();
        end
        drain();

        cfg_load = 1'b1; cfg_dly = 4'd0;
        tick();
        chk("cfg0.dly_cur", int'(dly_cur), 1);
        cfg_dly = 4'd15;
        tick();
        cfg_load = 1'b0;
        chk("cfg15.dly_cur", int'(dly_cur), 8);

        // rejected config while busy, then the same request accepted under flush
        x_pre = 11'd1; valid_pre = 1'b1;
        tick();
        idle_in();
        chk("rej.busy", int'(busy), 1);
        cfg_load = 1'b1; cfg_dly = 4'd2;
        tick();
        cfg_load = 1'b0;
        chk("rej.cfg_err", int'(cfg_err), 1);
        chk("rej.dly_cur", int'(dly_cur), 8);
        tick();
        chk("rej.err_clear", int'(cfg_err), 0);
        cfg_load = 1'b1; cfg_dly = 4'd2; flush = 1'b1;
        tick();
        idle_in();
        chk("acc.dly_cur", int'(dly_cur), 2);
        chk("acc.cfg_err", int'(cfg_err), 0);
        chk("acc.busy", int'(busy), 0);

        // reset mid-stream with three entries in flight (delay 8 keeps them all inside)
        cfg_load = 1'b1; cfg_dly = 4'd8;
        tick();
        for (int k = 0; k < 3; k++) begin
            cfg_load = 1'b0;
            x_pre = 11'(20 + k); y_pre = 11'(30 + k); valid_pre = 1'b1; done_pre = 1'b1;
            tick();
        end
        idle_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst.x", int'(x), 0);
        chk("mrst.y", int'(y), 0);
        chk("mrst.valid", int'(valid), 0);
        chk("mrst.busy", int'(busy), 0);
        chk("mrst.dly_cur", int'(dly_cur), 3);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("mrst.stale%0d", k), int'(valid | done), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coord_delay_line.md
# coord_delay_line

Parametrised, stallable delay line for coordinate/flag streams. Carries `x`, `y`, `valid` and `done` through a register pipeline of up to MAX_DEPTH stages. Output delay is selectable at run time, so the same block aligns coordinates with memory-read or arithmetic pipelines of different latency. It sits between the coordinate generator (line/shape drawer) and the consumer that needs its results aligned with later-ready data.

## Interface

**Parameters**
- `W`, 11: coordinate width.
- `MAX_DEPTH`, 8: number of physical stages (≥2).
- `DEFAULT_DLY`, 3: delay loaded at reset (1..MAX_DEPTH).
- `DW`, $clog2(MAX_DEPTH+1): width of the delay-select fields.

**Ports**
- `clk`, in, 1: the single clock; all logic on posedge.
- `reset`, in, 1: synchronous, active-high reset.
- `en`, in, 1: advance enable; 0 = stall (all stages hold).
- `flush`, in, 1: invalidate all in-flight entries.
- `x_pre`, `y_pre`, in, W: input coordinates.
- `valid_pre`, in, 1: input entry valid.
- `done_pre`, in, 1: input done flag, travels with the entry.
- `cfg_load`, in, 1: request to change the delay.
- `cfg_dly`, in, DW: requested delay.
- `x`, `y`, out, W: delayed coordinates.
- `valid`, out, 1: delayed valid.
- `done`, out, 1: delayed done.
- `busy`, out, 1: any stage holds a valid or done bit.
- `dly_cur`, out, DW: delay currently in effect.
- `cfg_err`, out, 1: one-cycle pulse on a rejected `cfg_load`.

## Operation

- **Stages.** Stages s[0..MAX_DEPTH-1] each hold {x, y, v, d}.
- **Advance (`en`=1).** s[0] ← inputs, s[k] ← s[k-1].
- **Stall (`en`=0).** All stages and outputs hold.
- **Output tap.** Outputs {x, y, valid, done} = s[dly_cur-1]. This is a mux from registers, with no extra register.
- **Done without valid.** `done` propagates independently of `valid`, so a done-only entry (`valid_pre`=0, `done_pre`=1) still emerges after the delay.
- **Flush.** `flush`=1 clears v and d in every stage at the edge. Data fields are untouched. The input presented in that cycle is dropped. `flush` has priority over `en`.
- **Reset.** Clears all stage fields to 0, `cfg_err` to 0, and sets `dly_cur` = DEFAULT_DLY. Reset has priority over `flush`, `en` and `cfg_load`.
- **Delay clamping.** `cfg_dly` = 0 is treated as 1. Values > MAX_DEPTH are treated as MAX_DEPTH.
- **Config accept.** `cfg_load` is accepted when `busy`=0 or `flush`=1 in the same cycle. `dly_cur` takes the clamped value at that edge.
- **Config reject.** Otherwise `cfg_load` is ignored, `dly_cur` is unchanged, and `cfg_err`=1 for the next cycle only.
- **`busy`.** OR of v|d over all MAX_DEPTH stages, including stages beyond the tap. These drain only while `en`=1.

## Timing

- **Latency.** Exactly `dly_cur` enabled cycles from input sample to output. With no stalls, an input sampled at edge N appears after edge N+`dly_cur`-1, i.e. valid in cycle N+`dly_cur`.
- **Default behaviour.** With DEFAULT_DLY=3, `en` tied 1 and no flush, the block reproduces a fixed 3-cycle x/y/done delay.
- **Stalls.** A stall of k cycles adds k cycles of latency. No entry is lost or duplicated.
- **Output reset values.** After reset: `x`=`y`=0, `valid`=`done`=0, `busy`=0, `dly_cur`=DEFAULT_DLY, `cfg_err`=0.
- **Delay change.** A new `dly_cur` is visible at the outputs in the cycle after acceptance.
- **Simultaneous `flush` + `valid_pre`.** The entry is discarded.
- **Simultaneous `flush` + `cfg_load`.** The config is accepted.
- **Simultaneous `flush` + `en`=0.** The flush still happens.
- **Reset mid-stream.** All in-flight entries are lost, and outputs go to reset values the cycle after.

## Structure

- **Package `delay_pkg`.** Holds the default constants (W=11, MAX_DEPTH=8, DEFAULT_DLY=3). Also holds a packed struct typedef `dl_entry_t` {x, y, v, d} parametrised by the default W, used for stage storage.
- **Sub-module `dl_stage`.** One register stage: entry in/out, `en`, `flush`, `reset`. It is instantiated MAX_DEPTH times in a generate loop.
- **Top level.** The top holds the tap mux, the `busy` OR-reduce, and the config register with clamp and error logic.

## Test plan

1. Reset, default delay 3, `en`=1; apply (x=5,y=9,valid=1,done=0), then (x=6,y=10,valid=1,done=1) -> outputs (5,9,1,0) 3 cycles after the first input, then (6,10,1,1) the next cycle; `valid`=0 before that.
2. Stall: same stream with `en`=0 for 2 cycles after the first input -> output delayed by 5 cycles, order intact, no duplicates.
3. Flush with 2 entries in flight -> `valid`/`done` never asserted for them; `busy`=0 the cycle after the flush.
4. Idle, `cfg_load`=1, `cfg_dly`=6 -> `dly_cur`=6; next entry emerges after 6 cycles. Then `cfg_dly`=0 gives `dly_cur`=1, and `cfg_dly`=15 gives `dly_cur`=8.
5. `cfg_load` while `busy`=1 -> `cfg_err` pulses exactly 1 cycle and `dly_cur` is unchanged; the same request with `flush`=1 is accepted.
6. Reset asserted mid-stream with 3 entries in flight -> all outputs 0 and `dly_cur`=3 the next cycle; no stale entry ever appears.
